// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl -- frame sequencer for the 3x3 window generator.
//
// On an accepted start the block resets the window generator for one cycle,
// then streams WIDTH*HEIGHT pixels in raster order from a synchronous-read
// frame memory into it. It moves at most one pixel per clock and stalls on
// hold without losing pixels. It counts emitted windows and pulses done at
// end of frame.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start, base_addr     frame request (sampled in IDLE), frame base address
//   hold                 downstream stall; no pixel is pushed while high
//   mem_en, mem_addr     memory read request
//   mem_rdata            read data, valid one cycle after mem_en
//   lb_rst               window generator reset (rst or CLEAR state)
//   lb_valid, lb_pix     pixel stream into the window generator
//   win_valid            window strobe from the window generator
//   busy, done           frame in progress / one-cycle end-of-frame pulse
//   win_count, win_err   windows seen this frame / count mismatch flag
module conv_frame_ctrl #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned BITW   = 8,
  parameter int unsigned ADDRW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic             hold,
  output logic             mem_en,
  output logic [ADDRW-1:0] mem_addr,
  input  logic [BITW-1:0]  mem_rdata,
  output logic             lb_rst,
  output logic             lb_valid,
  output logic [BITW-1:0]  lb_pix,
  input  logic             win_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      win_count,
  output logic             win_err
);

  localparam int unsigned N       = WIDTH * HEIGHT;
  localparam int unsigned CW      = $clog2(N + 1);
  localparam logic [31:0] EXP_WIN = 32'((WIDTH - 2) * (HEIGHT - 2));

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDRW-1:0]  base_q;
  logic [CW-1:0]     idx;
  logic [CW-1:0]     pushed;
  logic              rd_pend;     // a read issued last cycle returns now
  logic              skid_full;
  logic [BITW-1:0]   skid_data;

  logic              issue;
  logic              push_skid;
  logic              push_rd;
  logic              capture;

  // Next state plus the issue/delivery decisions. Issuing only with the skid
  // empty means a returning read and a full skid can never coincide.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push_skid = 1'b0;
    push_rd   = 1'b0;
    capture   = 1'b0;

    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: state_nxt = FETCH;
      FETCH: begin
        issue = !hold && !skid_full;
        if (issue && idx == CW'(N - 1)) state_nxt = DRAIN;
      end
      // pushed reaches N one cycle before this check fires, leaving room for
      // the window generator's registered win_valid on the last pixel.
      DRAIN: if (pushed == CW'(N)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state == FETCH || state == DRAIN) begin
      if (skid_full && !hold)      push_skid = 1'b1;
      else if (rd_pend && !hold)   push_rd   = 1'b1;
      else if (rd_pend && hold)    capture   = 1'b1;
    end
  end

  // Combinational outputs are forced to their reset values while rst is high.
  always_comb begin
    mem_en   = issue && !rst;
    mem_addr = mem_en ? base_q + ADDRW'(idx) : '0;
    lb_valid = (push_skid || push_rd) && !rst;
    lb_pix   = '0;
    if (lb_valid) lb_pix = push_skid ? skid_data : mem_rdata;
    lb_rst   = rst || (state == CLEAR);
    busy     = (state != IDLE) && !rst;
    done     = (state == DONE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      idx       <= '0;
      pushed    <= '0;
      rd_pend   <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      win_count <= '0;
      win_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= issue;

      if (state == IDLE && start) begin
        base_q    <= base_addr;
        idx       <= '0;
        pushed    <= '0;
        win_count <= '0;
        win_err   <= 1'b0;
      end else begin
        if (issue)                 idx       <= idx + CW'(1);
        if (push_skid || push_rd)  pushed    <= pushed + CW'(1);
        if (state != IDLE && win_valid) win_count <= win_count + 32'd1;
        if (state == DONE)         win_err   <= (win_count != EXP_WIN);
      end

      if (capture) begin
        skid_full <= 1'b1;
        skid_data <= mem_rdata;
      end else if (push_skid) begin
        skid_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with WIDTH=HEIGHT=4. The memory returns
// the low byte of the address, so pixel k of a frame at base b is (b+k)&0xFF.
// A stub window generator raises win_valid one cycle after each push whose
// raster position has row>=2 and col>=2.
module tb_conv_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        hold;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        lb_rst;
  logic        lb_valid;
  logic [7:0]  lb_pix;
  logic        win_valid;
  logic        busy;
  logic        done;
  logic [31:0] win_count;
  logic        win_err;
  logic        wv_kill = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  conv_frame_ctrl #(.WIDTH(4), .HEIGHT(4), .BITW(8), .ADDRW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lb_rst(lb_rst), .lb_valid(lb_valid), .lb_pix(lb_pix),
    .win_valid(win_valid), .busy(busy), .done(done),
    .win_count(win_count), .win_err(win_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_addr[7:0];
  end

  int col, row;
  always_ff @(posedge clk) begin
    if (lb_rst) begin
      col <= 0; row <= 0; win_valid <= 1'b0;
    end else begin
      win_valid <= lb_valid && !wv_kill && row >= 2 && col >= 2;
      if (lb_valid) begin
        if (col == 3) begin col <= 0; row <= row + 1; end
        else col <= col + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // per-frame observations
  int          npush, pix_bad, hold_viol, done_cnt, done_rel, first_push, n_issue;
  logic [15:0] addr_log [3];
  logic        busy_r1, lbrst_r1, lbrst_r2, werr_r1, busy_after, werr_final;
  logic        prst_busy, prst_valid;
  logic [31:0] wc_final, prst_wc;

  // Rel cycle 0 is the edge that samples start; each cycle's inputs are
  // driven 1 time unit after its opening edge and outputs sampled 3 later.
  task automatic run_frame(input logic [15:0] b, input logic [63:0] hpat,
                           input int restart_at, input int rst_at);
    logic [7:0] ep;
    npush = 0; pix_bad = 0; hold_viol = 0; done_cnt = 0; done_rel = -1;
    first_push = -1; n_issue = 0; wc_final = 32'hFFFF_FFFF; werr_final = 1'bx;
    busy_after = 1'bx;
    for (int i = 0; i < 3; i++) addr_log[i] = 16'hDEAD;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int rel = 1; rel < 120; rel++) begin
      hold  = (rel < 64) ? hpat[rel] : 1'b0;
      start = (rel == restart_at);
      rst   = (rel == rst_at);
      #3;
      if (rel == 1) begin busy_r1 = busy; lbrst_r1 = lb_rst; werr_r1 = win_err; end
      if (rel == 2) lbrst_r2 = lb_rst;
      if (mem_en) begin
        if (n_issue < 3) addr_log[n_issue] = mem_addr;
        n_issue++;
      end
      if (lb_valid) begin
        ep = b[7:0] + 8'(npush);
        if (lb_pix !== ep) pix_bad++;
        if (hold) hold_viol++;
        if (npush == 0) first_push = rel;
        npush++;
      end
      if (done) begin done_cnt++; done_rel = rel; end
      if (rel == rst_at + 1) begin
        prst_busy = busy; prst_valid = lb_valid; prst_wc = win_count;
        break;
      end
      if (done_cnt > 0 && rel == done_rel + 1) begin
        busy_after = busy; wc_final = win_count; werr_final = win_err;
        break;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_lb_valid", 32'(lb_valid), 0);
    check("rst_lb_pix", 32'(lb_pix), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_win_count", win_count, 0);
    check("rst_win_err", 32'(win_err), 0);
    check("rst_lb_rst", 32'(lb_rst), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // plain frame, no stall
    run_frame(16'h0000, 64'h0, -1, -1);
    check("a_busy_c1", 32'(busy_r1), 1);
    check("a_lbrst_c1", 32'(lbrst_r1), 1);
    check("a_lbrst_c2", 32'(lbrst_r2), 0);
    check("a_first_push", 32'(first_push), 3);
    check("a_npush", 32'(npush), 16);
    check("a_issues", 32'(n_issue), 16);
    check("a_pix_order", 32'(pix_bad), 0);
    check("a_done_cnt", 32'(done_cnt), 1);
    check("a_done_cycle", 32'(done_rel), 20);
    check("a_win_count", wc_final, 4);
    check("a_win_err", 32'(werr_final), 0);
    check("a_busy_after", 32'(busy_after), 0);

    // hold on cycles 5,6,7 and 10: 4 stall cycles + 2 bubbles
    run_frame(16'h0000, 64'h4E0, -1, -1);
    check("b_npush", 32'(npush), 16);
    check("b_pix_order", 32'(pix_bad), 0);
    check("b_push_in_hold", 32'(hold_viol), 0);
    check("b_done_cycle", 32'(done_rel), 26);
    check("b_win_count", wc_final, 4);

    // address wrap
    run_frame(16'hFFFE, 64'h0, -1, -1);
    check("c_addr0", 32'(addr_log[0]), 32'h0000_FFFE);
    check("c_addr1", 32'(addr_log[1]), 32'h0000_FFFF);
    check("c_addr2", 32'(addr_log[2]), 32'h0000_0000);
    check("c_pix_order", 32'(pix_bad), 0);
    check("c_done_cycle", 32'(done_rel), 20);

    // second start mid-frame is ignored
    run_frame(16'h0000, 64'h0, 8, -1);
    check("d_done_cnt", 32'(done_cnt), 1);
    check("d_done_cycle", 32'(done_rel), 20);
    check("d_win_count", wc_final, 4);

    // reset mid-frame, then a clean frame
    run_frame(16'h0000, 64'h0, -1, 9);
    check("e_busy", 32'(prst_busy), 0);
    check("e_lb_valid", 32'(prst_valid), 0);
    check("e_win_count", prst_wc, 0);
    check("e_done_cnt", 32'(done_cnt), 0);
    run_frame(16'h0000, 64'h0, -1, -1);
    check("f_lbrst_c1", 32'(lbrst_r1), 1);
    check("f_npush", 32'(npush), 16);
    check("f_pix_order", 32'(pix_bad), 0);
    check("f_done_cycle", 32'(done_rel), 20);
    check("f_win_count", wc_final, 4);

    // window generator silent: done still comes, err flagged
    wv_kill = 1'b1;
    run_frame(16'h0000, 64'h0, -1, -1);
    check("g_done_cnt", 32'(done_cnt), 1);
    check("g_win_count", wc_final, 0);
    check("g_win_err", 32'(werr_final), 1);
    wv_kill = 1'b0;

    // err clears on the next accepted start
    run_frame(16'h0000, 64'h0, -1, -1);
    check("h_err_cleared", 32'(werr_r1), 0);
    check("h_win_err", 32'(werr_final), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
